arith_scheduler: RTL and testbench

ARITH_SCHEDULER -- requirements
Module: arith_scheduler

---
 rtl/arith_scheduler_pkg.sv | 89 ++++++++
 rtl/arith_scheduler_if.sv | 41 ++++
 rtl/arith_scheduler_rr_arbiter_2.sv | 45 ++++
 rtl/arith_scheduler.sv | 130 +++++++++++++
 tb/tb_arith_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_scheduler_pkg.sv
//------------------------------------------------------------------------------
// Module  : arith_sched_pkg
// Purpose : Shared types, sizes and arithmetic unit functions for the
//           arith_scheduler block.
//           - op_e     : requester opcode encoding
//           - state_e  : scheduler FSM states
//           - fixed_adder / fixed_multi / float_multi : the three units
// Number formats:
//           fixed : unsigned Q8.8. Add overflows on carry out. Mul keeps
//                   product bits [23:8] and overflows when any of [31:24]
//                   is set.
//           float : 1 sign, 5 exponent, 10 mantissa bits. Implicit leading
//                   one, no exponent bias, so value = 1.m * 2^e. Overflow
//                   when the normalised exponent exceeds 31. The raw result
//                   keeps the low 5 exponent bits. The mantissa is truncated.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package arith_sched_pkg;

  localparam int DATA_W  = 16;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    OP_FIX_ADD = 2'b00,
    OP_FIX_MUL = 2'b01,
    OP_FLT_MUL = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              overflow;
  } unit_out_t;

  function automatic unit_out_t fixed_adder(input logic [15:0] a, input logic [15:0] b);
    unit_out_t  o;
    logic [16:0] sum;
    sum        = 17'(a) + 17'(b);
    o.result   = sum[15:0];
    o.overflow = sum[16];
    return o;
  endfunction

  function automatic unit_out_t fixed_multi(input logic [15:0] a, input logic [15:0] b);
    unit_out_t   o;
    logic [31:0] prod;
    logic [7:0]  unused_frac;
    prod        = 32'(a) * 32'(b);
    unused_frac = prod[7:0];
    o.result    = prod[23:8];
    o.overflow  = |prod[31:24];
    return o;
  endfunction

  function automatic unit_out_t float_multi(input logic [15:0] a, input logic [15:0] b);
    unit_out_t   o;
    logic [10:0] ma, mb;
    logic [21:0] prod;
    logic [6:0]  exp_sum;
    logic [9:0]  man;
    logic [9:0]  unused_lsb;
    ma         = {1'b1, a[9:0]};
    mb         = {1'b1, b[9:0]};
    prod       = 22'(ma) * 22'(mb);
    exp_sum    = 7'(a[14:10]) + 7'(b[14:10]);
    unused_lsb = prod[9:0];
    // Product of two 1.x mantissas lies in [1,4); renormalise when >= 2.
    if (prod[21]) begin
      man     = prod[20:11];
      exp_sum = exp_sum + 7'd1;
    end else begin
      man     = prod[19:10];
    end
    o.result   = {a[15] ^ b[15], exp_sum[4:0], man};
    o.overflow = |exp_sum[6:5];
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arith_scheduler_if.sv
//------------------------------------------------------------------------------
// Module  : arith_sched_if
// Purpose : Request/response bundle of the arith_scheduler.
//           master : requesters + response consumer (drives requests)
//           slave  : the scheduler
// Signals : req_valid/req_ready (per requester), req_op, req_a, req_b,
//           rsp_valid/rsp_ready, rsp_id, rsp_result, rsp_overflow, rsp_err,
//           busy
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface arith_sched_if;
  import arith_sched_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2*NUM_REQ-1:0]      req_op;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_overflow;
  logic                      rsp_err;
  logic                      busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_err, busy
  );

endinterface

`default_nettype wire

// File: rtl/arith_scheduler_rr_arbiter_2.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter_2
// Purpose : Two-way round-robin arbiter. A lone requester always wins; on a
//           tie the priority pointer decides. The pointer moves to the
//           non-granted requester only on an accept strobe.
// Ports   : clk, rst_n (async, active-low)
//           req[1:0]    request vector
//           accept      a grant was taken this cycle
//           grant[1:0]  one-hot grant (combinational)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_2 (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [1:0] req,
  input  wire logic       accept,
  output logic      [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // After granting requester 0 the pointer favours 1, and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= grant[0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/arith_scheduler.sv
//------------------------------------------------------------------------------
// Module  : arith_scheduler
// Purpose : Accepts one arithmetic request at a time from two requesters
//           (round-robin), executes it for EXEC_CYCLES cycles and holds the
//           response until the consumer takes it.
// Params  : EXEC_CYCLES  cycles spent in EXEC per operation (1..8)
// Ports   : clk, rst_n (async, active-low)
//           bus  arith_sched_if.slave (request/response bundle and busy)
// Config  : ARITH_SCHED_SATURATE_EN  when defined, overflowing results
//           saturate (fixed: 16'hFFFF, float: {sign,5'b11111,10'b0});
//           otherwise the wrapped unit output is returned.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module arith_scheduler
  import arith_sched_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input wire logic      clk,
  input wire logic      rst_n,
  arith_sched_if.slave  bus
);

  localparam int         CNT_W    = 3;
  localparam [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  op_e                op_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic               id_q;
  logic               rsp_id_q;
  logic [DATA_W-1:0]  rsp_result_q;
  logic               rsp_overflow_q;
  logic               rsp_err_q;

  logic [1:0]         grant;
  logic               accept;
  logic               accept_id;
  unit_out_t          unit;
  logic               err_nxt;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (bus.req_valid),
    .accept (accept),
    .grant  (grant)
  );

  // Held low throughout reset even though the arbiter output is live.
  assign bus.req_ready = (state == S_IDLE && rst_n) ? grant : 2'b00;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign accept_id     = bus.req_ready[1];

  assign bus.rsp_valid    = (state == S_RESP);
  assign bus.busy         = (state != S_IDLE);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_err      = rsp_err_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)        state_nxt = S_EXEC;
      S_EXEC:  if (cnt == '0)     state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Unit selection from the latched opcode; reserved opcode yields zero.
  always_comb begin
    unit    = '0;
    err_nxt = 1'b0;
    case (op_q)
      OP_FIX_ADD: unit    = fixed_adder(a_q, b_q);
      OP_FIX_MUL: unit    = fixed_multi(a_q, b_q);
      OP_FLT_MUL: unit    = float_multi(a_q, b_q);
      default:    err_nxt = 1'b1;
    endcase
`ifdef ARITH_SCHED_SATURATE_EN
    if (unit.overflow) begin
      unit.result = (op_q == OP_FLT_MUL) ? {unit.result[15], 5'b11111, 10'b0}
                                         : 16'hFFFF;
    end
`else
    // Wrapped unit output is passed through unchanged.
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      op_q           <= OP_FIX_ADD;
      a_q            <= '0;
      b_q            <= '0;
      id_q           <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= op_e'(accept_id ? bus.req_op[3:2] : bus.req_op[1:0]);
        a_q  <= accept_id ? bus.req_a[31:16] : bus.req_a[15:0];
        b_q  <= accept_id ? bus.req_b[31:16] : bus.req_b[15:0];
        id_q <= accept_id;
        cnt  <= CNT_LOAD;
      end else if (state == S_EXEC) begin
        if (cnt == '0) begin
          rsp_id_q       <= id_q;
          rsp_result_q   <= unit.result;
          rsp_overflow_q <= unit.overflow;
          rsp_err_q      <= err_nxt;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arith_scheduler.sv
//------------------------------------------------------------------------------
// Module  : tb_arith_scheduler
// Purpose : Self-checking bench for arith_scheduler. Main instance runs with
//           EXEC_CYCLES=4, a second instance with EXEC_CYCLES=1.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_arith_scheduler;
  localparam int EC = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   ptr_m  = 0;

  always #5 clk = ~clk;

  arith_sched_if bus ();
  arith_sched_if bus1 ();

  arith_scheduler #(.EXEC_CYCLES(EC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  arith_scheduler #(.EXEC_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Reference model: {err, overflow, result}
  function automatic logic [17:0] model_op(input logic [1:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    longint p;
    int e, m, s;
    logic [15:0] res;
    logic ov, err;
    res = 16'h0; ov = 1'b0; err = 1'b0;
    case (op)
      2'd0: begin
        p = longint'(a) + longint'(b);
        ov = (p > 65535);
        res = 16'(p);
      end
      2'd1: begin
        p = longint'(a) * longint'(b);
        ov = ((p / 256) > 65535);
        res = 16'(p / 256);
      end
      2'd2: begin
        s = int'(a[15] ^ b[15]);
        e = int'(a[14:10]) + int'(b[14:10]);
        p = longint'(1024 + int'(a[9:0])) * longint'(1024 + int'(b[9:0]));
        if (p >= 2097152) begin
          e = e + 1;
          m = int'(p / 2048) - 1024;
        end else begin
          m = int'(p / 1024) - 1024;
        end
        ov = (e > 31);
        res = {1'(s), 5'(e), 10'(m)};
      end
      default: err = 1'b1;
    endcase
`ifdef ARITH_SCHED_SATURATE_EN
    if (ov) res = (op == 2'd2) ? {a[15] ^ b[15], 5'h1f, 10'h0} : 16'hFFFF;
`endif
    return {err, ov, res};
  endfunction

  // One full transaction on the main DUT. Entered shortly after a rising edge
  // with the DUT idle; returns shortly after the response handshake edge.
  task automatic txn(input logic [1:0] vm, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int stall, input bit drop,
                     output logic got_id, output logic [15:0] got_res,
                     output logic got_ov, output logic got_err);
    int win, n;
    logic [17:0] exp;
    logic [1:0] exp_ready;
    win = (vm == 2'b11) ? ptr_m : (vm[1] ? 1 : 0);
    bus.req_valid = vm; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    #1;
    exp_ready = 2'b01 << win;
    checks++;
    if (bus.req_ready !== exp_ready) begin
      errors++;
      $display("FAIL req_ready grant: got %b expected %b", bus.req_ready, exp_ready);
    end
    @(posedge clk); #1;
    ptr_m = 1 - win;
    exp = model_op(op[2*win +: 2], a[16*win +: 16], b[16*win +: 16]);
    if (drop) bus.req_valid = 2'b00;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != EC) begin
      errors++;
      $display("FAIL latency: got %0d edges expected %0d", n, EC);
    end
    got_id = bus.rsp_id; got_res = bus.rsp_result;
    got_ov = bus.rsp_overflow; got_err = bus.rsp_err;
    checks++;
    if ({bus.busy, got_id, got_err, got_ov, got_res} !== {1'b1, 1'(win), exp}) begin
      errors++;
      $display("FAIL response: got busy=%b id=%b err=%b ov=%b res=%h expected id=%0d err=%b ov=%b res=%h",
               bus.busy, got_id, got_err, got_ov, got_res, win, exp[17], exp[16], exp[15:0]);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_id, bus.rsp_err, bus.rsp_overflow,
           bus.rsp_result} !== {1'b1, 1'b1, 2'b00, 1'(win), exp}) begin
        errors++;
        $display("FAIL stall hold: got valid=%b busy=%b ready=%b id=%b err=%b ov=%b res=%h",
                 bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_id, bus.rsp_err,
                 bus.rsp_overflow, bus.rsp_result);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL release: got valid=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b11; bus1.req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_id, bus.rsp_result,
         bus.rsp_overflow, bus.rsp_err} !== 22'h0) begin
      errors++;
      $display("FAIL reset state: got valid=%b busy=%b ready=%b id=%b res=%h ov=%b err=%b expected all 0",
               bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_id, bus.rsp_result,
               bus.rsp_overflow, bus.rsp_err);
    end
    checks++;
    if ({bus1.rsp_valid, bus1.busy, bus1.req_ready} !== 4'h0) begin
      errors++;
      $display("FAIL reset state ec1: got valid=%b busy=%b ready=%b expected 0",
               bus1.rsp_valid, bus1.busy, bus1.req_ready);
    end
    bus.req_valid = 2'b00; bus1.req_valid = 2'b00;
    rst_n = 1'b1;
    ptr_m = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_ec1();
    bus1.req_valid = 2'b01; bus1.req_op = 4'b0000;
    bus1.req_a = 32'h0000_0180; bus1.req_b = 32'h0000_0080;
    #1;
    checks++;
    if (bus1.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL ec1 ready: got %b expected 01", bus1.req_ready);
    end
    @(posedge clk); #1;
    bus1.req_valid = 2'b00;
    @(posedge clk); #1;
    checks++;
    if ({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_err, bus1.rsp_overflow, bus1.rsp_result} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 16'h0200}) begin
      errors++;
      $display("FAIL ec1 add: got valid=%b id=%b err=%b ov=%b res=%h expected 1 0 0 0 0200",
               bus1.rsp_valid, bus1.rsp_id, bus1.rsp_err, bus1.rsp_overflow, bus1.rsp_result);
    end
    bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.rsp_ready = 1'b0;
  endtask

  task automatic test_directed();
    logic id, ov, er;
    logic [15:0] r;
    logic [15:0] sat_exp;
`ifdef ARITH_SCHED_SATURATE_EN
    sat_exp = 16'hFFFF;
`else
    sat_exp = 16'h0000;
`endif
    txn(2'b10, 4'b0100, 32'h0200_0000, 32'h0300_0000, 0, 1'b1, id, r, ov, er);
    checks++;
    if ({id, ov, r} !== {1'b1, 1'b0, 16'h0600}) begin
      errors++;
      $display("FAIL fixmul: got id=%b ov=%b res=%h expected 1 0 0600", id, ov, r);
    end
    txn(2'b10, 4'b0100, 32'h8000_0000, 32'h0200_0000, 0, 1'b1, id, r, ov, er);
    checks++;
    if ({ov, r} !== {1'b1, sat_exp}) begin
      errors++;
      $display("FAIL fixmul ovf: got ov=%b res=%h expected 1 %h", ov, r, sat_exp);
    end
    txn(2'b01, 4'b0010, 32'h0000_0400, 32'h0000_0600, 0, 1'b1, id, r, ov, er);
    checks++;
    if ({id, er, ov, r} !== {1'b0, 1'b0, 1'b0, 16'h0A00}) begin
      errors++;
      $display("FAIL fltmul: got id=%b err=%b ov=%b res=%h expected 0 0 0 0a00", id, er, ov, r);
    end
  endtask

  task automatic test_drop();
    logic id, ov, er;
    logic [15:0] r;
    bus.req_valid = 2'b11;
    #2;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL drop: got busy=%b expected 0", bus.busy);
    end
    // Pointer must be unchanged: tie goes to the model pointer.
    txn(2'b11, 4'b0000, 32'h0001_0002, 32'h0003_0004, 0, 1'b1, id, r, ov, er);
  endtask

  task automatic test_backpressure();
    logic id, ov, er;
    logic [15:0] r;
    txn(2'b11, 4'b1111, 32'h1234_5678, 32'h9abc_def0, 5, 1'b0, id, r, ov, er);
    bus.req_valid = 2'b00;
    checks++;
    if ({er, ov, r} !== {1'b1, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reserved op: got err=%b ov=%b res=%h expected 1 0 0000", er, ov, r);
    end
  endtask

  task automatic test_reset_mid_exec();
    bit seen;
    bus.req_valid = 2'b01; bus.req_op = 4'b0000; bus.req_a = 32'h0000_0100; bus.req_b = 32'h0;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_id, bus.rsp_result,
         bus.rsp_overflow, bus.rsp_err} !== 22'h0) begin
      errors++;
      $display("FAIL reset mid exec: got valid=%b busy=%b ready=%b id=%b res=%h ov=%b err=%b expected all 0",
               bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_id, bus.rsp_result,
               bus.rsp_overflow, bus.rsp_err);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    ptr_m = 0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL aborted op: got activity after reset expected none");
    end
  endtask

  task automatic test_round_robin();
    logic id, ov, er;
    logic [15:0] r;
    logic [3:0] ids;
    for (int i = 0; i < 4; i++) begin
      txn(2'b11, 4'b0000, 32'h0010_0020, 32'h0001_0002, 0, 1'b0, id, r, ov, er);
      ids[i] = id;
    end
    bus.req_valid = 2'b00;
    checks++;
    if (ids !== 4'b1010) begin
      errors++;
      $display("FAIL rr order: got ids(3..0)=%b expected 1010", ids);
    end
  endtask

  task automatic test_random();
    logic id, ov, er;
    logic [15:0] r;
    logic [1:0] vm;
    for (int i = 0; i < 24; i++) begin
      vm = 2'($urandom_range(1, 3));
      txn(vm, 4'($urandom), $urandom, $urandom, $urandom_range(0, 3), 1'b1, id, r, ov, er);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 2'b00; bus.req_op = 4'h0; bus.req_a = 32'h0; bus.req_b = 32'h0;
    bus.rsp_ready = 1'b0;
    bus1.req_valid = 2'b00; bus1.req_op = 4'h0; bus1.req_a = 32'h0; bus1.req_b = 32'h0;
    bus1.rsp_ready = 1'b0;
    test_reset();
    test_add_ec1();
    test_directed();
    test_drop();
    test_backpressure();
    test_reset_mid_exec();
    test_round_robin();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors == 0) $display("TEST PASSED");
    else             $display("TEST FAILED");
    $finish;
  end

endmodule

`default_nettype wire
